mod6_updown_counter: RTL and testbench
======================================

Name: mod6_updown_counter

Overview:
- Synchronous modulo-N up/down counter, N = 6 by default.
- Counts 0..5 and wraps in either direction, selected by a per-cycle direction input.
- Leaf block used as a small sequencing/phase counter. Verified standalone through an interface that drives reset and dir and samples q.

Parameters:
- MODULUS, 6: number of states; count range 0..MODULUS-1; must be >= 2.
- WIDTH, 3: width of q; must satisfy 2**WIDTH >= MODULUS. An elaboration-time check fails if this is violated.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-high reset
- dir  input  1  count direction: 1 = up, 0 = down; sampled at each rising clk edge
- q  output  WIDTH  current count, driven directly from a register

Behaviour:
- Reset:
  - reset high forces q = 0 immediately, without waiting for a clock edge.
  - q holds 0 for as long as reset is high.
  - Release is synchronous to the next rising clk edge; the first count update happens on the first rising edge after reset is low.
- Up count (dir=1 at the edge):
  - q < MODULUS-1: q <= q+1.
  - q == MODULUS-1 (5): q <= 0.
- Down count (dir=0 at the edge):
  - q > 0: q <= q-1.
  - q == 0: q <= MODULUS-1 (5).
- Latency: one cycle; q reflects the dir sampled at the previous edge. No enable, so the counter steps every cycle it is out of reset.
- Direction change takes effect on the very next edge, with no dead cycle. Example: sequence 3 (up) -> 4, then dir=0 -> 3.
- Out-of-range values (q >= MODULUS, which cannot occur after reset):
  - Up: next q = 0.
  - Down: next q = MODULUS-1.
  - This guarantees the counter recovers from an illegal value within one cycle.
- Reset asserted mid-count: q goes to 0 asynchronously, regardless of dir or clk.
- All arithmetic is WIDTH bits. Wrap is decided by compare against MODULUS-1 and 0, never by natural binary overflow.

Optional Feature:
- Macro: MOD6_UPDOWN_COUNTER_WRAP_EN.
- Defined:
  - Adds output port `wrap` (1 bit, registered).
  - `wrap` pulses high for exactly one cycle, coincident with q taking a wrapped value: 5 -> 0 when up, or 0 -> 5 when down.
  - Reset value of `wrap` is 0; it is cleared asynchronously with reset.
  - The out-of-range recovery step does not assert `wrap`.
- Not defined: no `wrap` port exists; the core counting behaviour is identical.

Decomposition:
- Package mod6_counter_pkg holds:
  - localparams DIR_UP = 1'b1 and DIR_DOWN = 1'b0
  - default MODULUS = 6 and WIDTH = 3
  - a typedef for the count type, logic [WIDTH-1:0]
- One sub-module: mod6_counter_next. It is purely combinational: it takes q and dir and returns the next count, plus the wrap indication when the feature is compiled in.
- The top level holds only the asynchronous-reset register(s) and the parameter checks.

Test Plan:
1. Reset: hold reset=1 for 2 cycles with dir=1 -> q=0 throughout. Release reset; after 1 edge -> q=1.
2. Up wrap: dir=1 for 8 edges after reset -> q sequence 1,2,3,4,5,0,1,2 (wrap pulses on the 5->0 step if enabled).
3. Down wrap: from reset, dir=0 for 7 edges -> q sequence 5,4,3,2,1,0,5 (wrap pulses on each 0->5 step if enabled).
4. Direction flip: count up to q=4, set dir=0 -> next q=3. Set dir=1 -> next q=4. No skipped or held states.
5. Asynchronous reset mid-count: at q=3, assert reset between clock edges -> q=0 before the next rising edge. Hold 1 cycle, release with dir=0 -> first edge gives q=5.
6. Parameterized: MODULUS=4, WIDTH=2, dir=1 -> 1,2,3,0. dir=0 from 0 -> 3. An illegal config such as MODULUS=9, WIDTH=3 fails elaboration.

Source files
------------

// File: rtl/mod6_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mod6_counter_pkg
// Purpose  : Shared constants and types for the modulo-N up/down counter.
//            - DIR_UP / DIR_DOWN : encodings of the dir input
//            - DEFAULT_MODULUS   : default number of count states (6)
//            - DEFAULT_WIDTH     : default count width in bits (3)
//            - count_t           : count type at the default width
// Options  : The counter's wrap pulse is compiled in only when the macro
//            MOD6_UPDOWN_COUNTER_WRAP_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
package mod6_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int DEFAULT_MODULUS = 6;
    localparam int DEFAULT_WIDTH   = 3;

    typedef logic [DEFAULT_WIDTH-1:0] count_t;

endpackage : mod6_counter_pkg
`default_nettype wire

// File: rtl/mod6_counter_next.sv
`default_nettype none
// ============================================================================
// Module   : mod6_counter_next
// Purpose  : Purely combinational next-count logic for the modulo-N up/down
//            counter. Wrapping is decided by compare against MODULUS-1 and 0,
//            never by binary overflow, so any MODULUS <= 2**WIDTH works.
// Ports    : i_q      [WIDTH-1:0] in  current count
//            i_dir                in  1 = count up, 0 = count down
//            o_q_next [WIDTH-1:0] out next count
//            o_wrap               out next step is a legal wrap
//                                     (only with MOD6_UPDOWN_COUNTER_WRAP_EN)
// Options  : MOD6_UPDOWN_COUNTER_WRAP_EN adds o_wrap.
// Revision : 1.0 - initial release
// ============================================================================
module mod6_counter_next
    import mod6_counter_pkg::*;
#(
    parameter int MODULUS = DEFAULT_MODULUS,
    parameter int WIDTH   = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_dir,
    output logic [WIDTH-1:0] o_q_next
`ifdef MOD6_UPDOWN_COUNTER_WRAP_EN
   ,output logic             o_wrap
`endif
);

    localparam logic [WIDTH-1:0] c_max  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] c_zero = '0;
    localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);

    logic w_at_max;
    logic w_at_zero;
    logic w_out_of_range;

    assign w_at_max  = (i_q == c_max);
    assign w_at_zero = (i_q == c_zero);

    // When MODULUS fills the whole code space there are no illegal values;
    // skipping the compare avoids a comparison that is constant-false.
    generate
        if (MODULUS < (2 ** WIDTH)) begin : g_range_check
            assign w_out_of_range = (i_q > c_max);
        end else begin : g_range_full
            assign w_out_of_range = 1'b0;
        end
    endgenerate

    // Illegal values are recovered in one step: to 0 going up, to
    // MODULUS-1 going down, matching where a legal wrap would land.
    always_comb begin
        o_q_next = i_q;
        if (i_dir == DIR_UP) begin
            if (w_out_of_range || w_at_max) begin
                o_q_next = c_zero;
            end else begin
                o_q_next = i_q + c_one;
            end
        end else begin
            if (w_out_of_range || w_at_zero) begin
                o_q_next = c_max;
            end else begin
                o_q_next = i_q - c_one;
            end
        end
    end

`ifdef MOD6_UPDOWN_COUNTER_WRAP_EN
    // w_at_max / w_at_zero are only true for in-range values, so the
    // out-of-range recovery step never reports a wrap.
    assign o_wrap = (i_dir == DIR_UP) ? w_at_max : w_at_zero;
`endif

endmodule : mod6_counter_next
`default_nettype wire

// File: rtl/mod6_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : mod6_updown_counter
// Purpose  : Modulo-MODULUS up/down counter (0..MODULUS-1) that steps every
//            clock it is out of reset, wrapping in either direction.
// Ports    : clk               in  rising-edge clock
//            reset             in  asynchronous active-high reset (q -> 0)
//            dir               in  1 = up, 0 = down, sampled at each edge
//            q     [WIDTH-1:0] out current count, straight from a register
//            wrap              out one-cycle pulse when q takes a wrapped
//                                  value (only with MOD6_UPDOWN_COUNTER_WRAP_EN)
// Options  : MOD6_UPDOWN_COUNTER_WRAP_EN adds the registered wrap output.
// Revision : 1.0 - initial release
// ============================================================================
module mod6_updown_counter
    import mod6_counter_pkg::*;
#(
    parameter int MODULUS = DEFAULT_MODULUS,
    parameter int WIDTH   = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dir,
    output logic [WIDTH-1:0] q
`ifdef MOD6_UPDOWN_COUNTER_WRAP_EN
   ,output logic             wrap
`endif
);

    // Reject configurations that cannot hold the count range.
    generate
        if (MODULUS < 2) begin : g_bad_modulus
            $error("mod6_updown_counter: MODULUS must be >= 2");
        end
        if ((2 ** WIDTH) < MODULUS) begin : g_bad_width
            $error("mod6_updown_counter: WIDTH too small for MODULUS");
        end
    endgenerate

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;

`ifdef MOD6_UPDOWN_COUNTER_WRAP_EN
    logic r_wrap;
    logic w_wrap;
`endif

    mod6_counter_next #(
        .MODULUS (MODULUS),
        .WIDTH   (WIDTH)
    ) u_next (
        .i_q      (r_q),
        .i_dir    (dir),
        .o_q_next (w_q_next)
`ifdef MOD6_UPDOWN_COUNTER_WRAP_EN
       ,.o_wrap   (w_wrap)
`endif
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else begin
            r_q <= w_q_next;
        end
    end

    assign q = r_q;

`ifdef MOD6_UPDOWN_COUNTER_WRAP_EN
    // Registered alongside r_q so the pulse lines up with the wrapped value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_wrap;
        end
    end

    assign wrap = r_wrap;
`endif

endmodule : mod6_updown_counter
`default_nettype wire

// File: tb/tb_mod6_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod6_updown_counter
// Purpose  : Scoreboard bench for mod6_updown_counter. Two instances share
//            clk/reset/dir: the default MODULUS=6/WIDTH=3 build and a
//            MODULUS=4/WIDTH=2 build. Each driven step pushes hand-computed
//            expectations; a monitor pops and compares after every edge.
// Options  : Define MOD6_UPDOWN_COUNTER_WRAP_EN to also check wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mod6_updown_counter;

    typedef struct packed {
        logic [2:0] q6;
        logic [1:0] q4;
        logic       w6;
        logic       w4;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       dir;
    logic [2:0] q6;
    logic [1:0] q4;
`ifdef MOD6_UPDOWN_COUNTER_WRAP_EN
    logic       wrap6;
    logic       wrap4;
`endif

    int   n_checks;
    int   n_fail;
    exp_t exp_q[$];

    mod6_updown_counter u_dut6 (
        .clk   (clk),
        .reset (reset),
        .dir   (dir),
        .q     (q6)
`ifdef MOD6_UPDOWN_COUNTER_WRAP_EN
       ,.wrap  (wrap6)
`endif
    );

    mod6_updown_counter #(
        .MODULUS (4),
        .WIDTH   (2)
    ) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .dir   (dir),
        .q     (q4)
`ifdef MOD6_UPDOWN_COUNTER_WRAP_EN
       ,.wrap  (wrap4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expectation per clock edge, checked 1 time unit later.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (q6 !== e.q6) begin
                    n_fail++;
                    $display("FAIL q6 @%0t: got %0d expected %0d", $time, q6, e.q6);
                end
                n_checks++;
                if (q4 !== e.q4) begin
                    n_fail++;
                    $display("FAIL q4 @%0t: got %0d expected %0d", $time, q4, e.q4);
                end
`ifdef MOD6_UPDOWN_COUNTER_WRAP_EN
                n_checks++;
                if (wrap6 !== e.w6) begin
                    n_fail++;
                    $display("FAIL wrap6 @%0t: got %0b expected %0b", $time, wrap6, e.w6);
                end
                n_checks++;
                if (wrap4 !== e.w4) begin
                    n_fail++;
                    $display("FAIL wrap4 @%0t: got %0b expected %0b", $time, wrap4, e.w4);
                end
`endif
            end
        end
    end

    // Drive one cycle's inputs on the falling edge and queue the values
    // expected after the following rising edge.
    task automatic step(input logic r, input logic d,
                        input int eq6, input int eq4,
                        input logic ew6, input logic ew4);
        exp_t e;
        @(negedge clk);
        reset = r;
        dir   = d;
        e.q6  = 3'(eq6);
        e.q4  = 2'(eq4);
        e.w6  = ew6;
        e.w4  = ew4;
        exp_q.push_back(e);
    endtask

    // Direct (unqueued) check of the asynchronous reset response.
    task automatic check_async(input string name);
        n_checks++;
        if (q6 !== 3'd0 || q4 !== 2'd0) begin
            n_fail++;
            $display("FAIL %s @%0t: got q6=%0d q4=%0d expected 0 0", name, $time, q6, q4);
        end
`ifdef MOD6_UPDOWN_COUNTER_WRAP_EN
        n_checks++;
        if (wrap6 !== 1'b0 || wrap4 !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_wrap @%0t: got %0b %0b expected 0 0", name, $time, wrap6, wrap4);
        end
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        dir      = 1'b1;
        #1;
        check_async("reset_at_start");

        // Reset held two cycles with dir=1: count stays at 0.
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);

        // Up count with wraps (mod-6 wraps once, mod-4 wraps twice).
        step(0, 1, 1, 1, 0, 0);
        step(0, 1, 2, 2, 0, 0);
        step(0, 1, 3, 3, 0, 0);
        step(0, 1, 4, 0, 0, 1);
        step(0, 1, 5, 1, 0, 0);
        step(0, 1, 0, 2, 1, 0);
        step(0, 1, 1, 3, 0, 0);
        step(0, 1, 2, 0, 0, 1);

        // Up to 4, then flip direction each edge with no dead cycle.
        step(0, 1, 3, 1, 0, 0);
        step(0, 1, 4, 2, 0, 0);
        step(0, 0, 3, 1, 0, 0);
        step(0, 1, 4, 2, 0, 0);
        step(0, 0, 3, 1, 0, 0);

        // Asynchronous reset between edges while q6 = 3.
        @(negedge clk);
        #2;
        reset = 1'b1;
        dir   = 1'b0;
        #1;
        check_async("async_reset");

        // Hold reset one more cycle, then count down from reset.
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 5, 3, 1, 1);
        step(0, 0, 4, 2, 0, 0);
        step(0, 0, 3, 1, 0, 0);
        step(0, 0, 2, 0, 0, 0);
        step(0, 0, 1, 3, 0, 1);
        step(0, 0, 0, 2, 0, 0);
        step(0, 0, 5, 1, 1, 0);

        // Up from 5 wraps to 0.
        step(0, 1, 0, 2, 1, 0);

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mod6_updown_counter
`default_nettype wire
